fullchip_inst_seq: RTL and testbench
====================================

Name: fullchip_inst_seq

Overview:
- Autonomous instruction sequencer that drives the 17-bit `inst` word and the `mem_in` bus of the fullchip attention core.
- Replaces the hand-driven stimulus sequence: Q write → K write → K load → execute → ofifo-to-pmem move.
- Pulls Q and K vectors from an upstream valid/ready source and reports completion with `done`.
- Sits between the host/DMA data source and the fullchip top-level.

Parameters:
- bw, 4, bit width of one vector element.
- pr, 8, elements per Q/K vector (`mem_in` width = pr*bw).
- col, 8, number of K vectors (dot-product columns); range 1..16.
- total_cycle, 8, number of Q vectors streamed; range 1..16.
- load_gap, 10, idle cycles between end of K load and start of execute.
- exec_gap, 11, idle cycles between end of execute and start of ofifo move.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run one full sequence; sampled only in IDLE.
- in_valid  in  1  upstream vector valid.
- in_data  in  pr*bw  upstream vector; element e occupies bits [(e+1)*bw-1 : e*bw].
- in_ready  out  1  sequencer accepts `in_data` this cycle.
- mem_in  out  pr*bw  registered vector to fullchip.
- inst  out  17  registered instruction word:
  - [16] ofifo_rd
  - [15:12] qkmem_add
  - [11:8] pmem_add
  - [7] execute
  - [6] load
  - [5] qmem_rd
  - [4] qmem_wr
  - [3] kmem_rd
  - [2] kmem_wr
  - [1] pmem_rd
  - [0] pmem_wr
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset: state=IDLE, all counters=0; inst=0, mem_in=0, in_ready=0, busy=0, done=0 on the cycle after the reset edge. Reset mid-sequence aborts immediately; no partial phase completes.
- All outputs are registered. In the cycle listings below, "cycle k" means the k-th cycle the outputs are presented in that state. Every inst bit not listed for a state is 0.
- IDLE: inst=0. When start=1, go to QWR. start while busy is ignored.
- QWR (combinational):
  - in_ready=1 while row < total_cycle.
  - Each in_valid&&in_ready edge registers mem_in<=in_data, qmem_wr<=1, qkmem_add<=row, then row++.
- QWR (stall): if in_valid=0, the next cycle has qmem_wr=0, qkmem_add held, mem_in held.
- QWR (exit): after row total_cycle-1 is accepted, in_ready drops in the same cycle it would otherwise be re-evaluated (combinational on state/row), and the state goes to KWR.
- KWR: identical to QWR using kmem_wr and col rows. Then go to GAP.
- GAP: 2 cycles, inst=0.
- LOAD: col+2 cycles with load=1.
  - Cycle 0: kmem_rd=0, add=0.
  - Cycles 1..col: kmem_rd=1, qkmem_add=k-1.
  - Cycle col+1: kmem_rd=0, add=0.
- WAIT1: load_gap cycles, inst=0.
- EXEC: total_cycle cycles with execute=1, qmem_rd=1, qkmem_add=k.
- WAIT2: exec_gap cycles, inst=0.
- MOVE: total_cycle cycles with ofifo_rd=1, pmem_wr=1, pmem_add=k; qkmem_add=0.
- DONE: 1 cycle with done=1 and inst=0, then IDLE. busy=0 in the DONE cycle.
- pmem_rd is always 0.
- mem_in holds its last accepted value outside QWR/KWR.
- Address fields are 4 bits wide; parameters above 16 are illegal. Elaboration must fail via a generate-time check.
- Stall-free latency: the first QWR output appears in the cycle after start is sampled, and done is asserted in cycle index `total_cycle + col + 2 + (col+2) + load_gap + total_cycle + exec_gap + total_cycle`. With defaults this is cycle 65, counting the first QWR cycle as 0.

Test Plan:
- Reset mid-run: reset asserted during EXEC → next cycle inst=0, busy=0. A following start runs a complete sequence again starting from Q row 0.
- Default run, in_valid tied 1: start pulse → inst shows:
  - qmem_wr for cycles 0-7 with qkmem_add 0..7.
  - kmem_wr for cycles 8-15.
  - load=1 for cycles 18-27, with kmem_rd and add 0..7 in cycles 19-26.
  - execute for cycles 38-45.
  - ofifo_rd/pmem_wr for cycles 57-64 with pmem_add 0..7.
  - done in cycle 65.
- Backpressure: in_valid low on alternate cycles during QWR → qmem_wr present only on accepted rows. Addresses stay contiguous 0..7 and mem_in matches each accepted in_data (e.g. 32'h76543210 lands at address 3). The sequence end shifts later by exactly the number of stall cycles.
- start during busy: pulse start at cycle 30 → ignored. Exactly one done pulse; no phase restarts.
- Boundary: col=1, total_cycle=1 →
  - one qmem_wr, one kmem_wr.
  - load high 3 cycles with kmem_rd only in the middle cycle.
  - single execute and single move cycle.
  - done at cycle 1+1+2+3+10+1+11+1=30.
- Back-to-back: start asserted in the cycle after done → second sequence begins with qkmem_add=0 and produces an identical timing trace.

Source files
------------

// File: rtl/fullchip_inst_seq.sv
// Instruction sequencer for the fullchip attention core.
// Pulls Q then K vectors from a valid/ready source and writes them into
// qmem/kmem. It then loads K into the array, executes one dot product per
// Q row, and finally moves the ofifo results into pmem before pulsing done.
// inst, mem_in, busy and done are registered. Each one shows, one clock
// later, the decision made in the state the FSM occupied in the previous
// cycle. in_ready is combinational on state and row.
module fullchip_inst_seq #(
  parameter int bw          = 4,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int load_gap    = 10,
  parameter int exec_gap    = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [pr*bw-1:0] in_data,
  output logic             in_ready,
  output logic [pr*bw-1:0] mem_in,
  output logic [16:0]      inst,
  output logic             busy,
  output logic             done
);

  // The address fields are 4 bits wide, and each wait phase needs at least one cycle.
  if (col < 1 || col > 16) begin : g_col_range
    $error("fullchip_inst_seq: col must be in 1..16");
  end
  if (total_cycle < 1 || total_cycle > 16) begin : g_tc_range
    $error("fullchip_inst_seq: total_cycle must be in 1..16");
  end
  if (load_gap < 1 || exec_gap < 1) begin : g_gap_range
    $error("fullchip_inst_seq: load_gap and exec_gap must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_GAP, S_LOAD, S_WAIT1, S_EXEC, S_WAIT2, S_MOVE, S_DONE
  } state_t;

  localparam logic [4:0]  QROWS      = 5'(total_cycle);
  localparam logic [4:0]  KROWS      = 5'(col);
  localparam logic [4:0]  QROW_LAST  = 5'(total_cycle - 1);
  localparam logic [4:0]  KROW_LAST  = 5'(col - 1);
  localparam logic [15:0] LOAD_KLAST = 16'(col);
  localparam logic [15:0] LOAD_LAST  = 16'(col + 1);
  localparam logic [15:0] W1_LAST    = 16'(load_gap - 1);
  localparam logic [15:0] EXEC_LAST  = 16'(total_cycle - 1);
  localparam logic [15:0] W2_LAST    = 16'(exec_gap - 1);

  state_t             state_q, state_d;
  logic [4:0]         row_q, row_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        cnt_m1;
  logic [16:0]        inst_q, inst_d;
  logic [pr*bw-1:0]   mem_q, mem_d;
  logic               busy_q, done_q;

  assign cnt_m1 = cnt_q - 16'd1;

  // Next-state, handshake and next instruction word.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    inst_d   = '0;
    mem_d    = mem_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_QWR;
          row_d   = '0;
          cnt_d   = '0;
        end
      end
      S_QWR: begin
        in_ready = (row_q < QROWS);
        if (in_ready && in_valid) begin
          inst_d[4]     = 1'b1;
          inst_d[15:12] = row_q[3:0];
          mem_d         = in_data;
          if (row_q == QROW_LAST) begin
            row_d   = '0;
            state_d = S_KWR;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          inst_d[15:12] = inst_q[15:12];
        end
      end
      S_KWR: begin
        in_ready = (row_q < KROWS);
        if (in_ready && in_valid) begin
          inst_d[2]     = 1'b1;
          inst_d[15:12] = row_q[3:0];
          mem_d         = in_data;
          if (row_q == KROW_LAST) begin
            row_d   = '0;
            cnt_d   = '0;
            state_d = S_GAP;
          end else begin
            row_d = row_q + 5'd1;
          end
        end else begin
          inst_d[15:12] = inst_q[15:12];
        end
      end
      S_GAP: begin
        if (cnt_q == 16'd1) begin
          cnt_d   = '0;
          state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        inst_d[6] = 1'b1;
        if (cnt_q >= 16'd1 && cnt_q <= LOAD_KLAST) begin
          inst_d[3]     = 1'b1;
          inst_d[15:12] = cnt_m1[3:0];
        end
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT1: begin
        if (cnt_q == W1_LAST) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_EXEC: begin
        inst_d[7]     = 1'b1;
        inst_d[5]     = 1'b1;
        inst_d[15:12] = cnt_q[3:0];
        if (cnt_q == EXEC_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT2;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT2: begin
        if (cnt_q == W2_LAST) begin
          cnt_d   = '0;
          state_d = S_MOVE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_MOVE: begin
        inst_d[16]   = 1'b1;
        inst_d[0]    = 1'b1;
        inst_d[11:8] = cnt_q[3:0];
        if (cnt_q == EXEC_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any sequence in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      inst_q  <= '0;
      mem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
      mem_q   <= mem_d;
      busy_q  <= (state_q != S_IDLE) && (state_q != S_DONE);
      done_q  <= (state_q == S_DONE);
    end
  end

  assign inst   = inst_q;
  assign mem_in = mem_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_fullchip_inst_seq.sv
// Bench for fullchip_inst_seq: a default-size instance (A) and a
// col=1/total_cycle=1 instance (B) run side by side.
// Sample index o counts bench samples taken 1 time unit after each rising
// edge. Start is presented at o=0, so output cycle k is seen at o=k+2.
module tb_fullchip_inst_seq;

  logic        clk;
  logic        reset;
  logic        start_a, start_b;
  logic        valid_a, valid_b;
  logic [31:0] data_a, data_b;
  logic        ready_a, ready_b;
  logic [31:0] mem_a, mem_b;
  logic [16:0] inst_a, inst_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;

  fullchip_inst_seq dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_data(data_a),
    .in_ready(ready_a), .mem_in(mem_a), .inst(inst_a), .busy(busy_a), .done(done_a)
  );

  fullchip_inst_seq #(.col(1), .total_cycle(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_data(data_b),
    .in_ready(ready_b), .mem_in(mem_b), .inst(inst_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  logic [16:0] tr_inst [0:159];
  logic [31:0] tr_mem  [0:159];
  logic        tr_done [0:159];
  logic        tr_busy [0:159];
  logic        tr_rdy  [0:159];
  logic [18:0] trb     [0:159];

  typedef struct {
    int          cyc;
    logic [16:0] inst;
    logic        done;
    logic        busy;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [31:0] qvec(input int r);
    return 32'h76543210 ^ (32'h01010101 * 32'(r ^ 3));
  endfunction

  function automatic logic [31:0] kvec(input int r);
    return 32'hC0DE0000 | 32'(r);
  endfunction

  // Expected {busy, done, inst} for output cycle k of an undisturbed run.
  function automatic logic [18:0] model(input int k, input int c, input int t);
    logic [16:0] r;
    logic        d, b;
    int          l0, e0, m0, d0, j;
    r  = '0;
    l0 = t + c + 2;
    e0 = l0 + c + 2 + 10;
    m0 = e0 + t + 11;
    d0 = m0 + t;
    d  = (k == d0);
    b  = (k >= 0) && (k < d0);
    j  = 0;
    if (k >= 0 && k < t) begin
      r[4] = 1'b1; r[15:12] = k[3:0];
    end else if (k >= t && k < t + c) begin
      j = k - t; r[2] = 1'b1; r[15:12] = j[3:0];
    end else if (k >= l0 && k < l0 + c + 2) begin
      j = k - l0; r[6] = 1'b1;
      if (j >= 1 && j <= c) begin
        j = j - 1; r[3] = 1'b1; r[15:12] = j[3:0];
      end
    end else if (k >= e0 && k < e0 + t) begin
      j = k - e0; r[7] = 1'b1; r[5] = 1'b1; r[15:12] = j[3:0];
    end else if (k >= m0 && k < m0 + t) begin
      j = k - m0; r[16] = 1'b1; r[0] = 1'b1; r[11:8] = j[3:0];
    end
    return {b, d, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one run of n samples and record both instances' outputs.
  task automatic run(input bit bp, input int n, input int start2, input int rst_at);
    int fa, fb;
    fa = 0;
    fb = 0;
    for (int o = 0; o < n; o++) begin
      tr_inst[o] = inst_a;
      tr_mem[o]  = mem_a;
      tr_done[o] = done_a;
      tr_busy[o] = busy_a;
      tr_rdy[o]  = ready_a;
      trb[o]     = {busy_b, done_b, inst_b};
      reset   = (o == rst_at);
      start_a = (o == 0) || (o == start2);
      start_b = (o == 0);
      valid_a = (bp && o <= 16) ? (o % 2 == 0) : 1'b1;
      valid_b = 1'b1;
      if (start_a) fa = 0;
      if (start_b) fb = 0;
      data_a = (fa < 8) ? qvec(fa) : kvec(fa - 8);
      data_b = (fb < 1) ? qvec(fb) : kvec(fb - 1);
      if (valid_a && ready_a) fa++;
      if (valid_b && ready_b) fb++;
      @(posedge clk);
      #1;
    end
    reset   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    int ndone;
    n_chk   = 0;
    n_err   = 0;
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    data_a  = '0;
    data_b  = '0;

    tbl[0]  = '{-1, 17'h00000, 1'b0, 1'b0};
    tbl[1]  = '{0,  17'h00010, 1'b0, 1'b1};
    tbl[2]  = '{7,  17'h07010, 1'b0, 1'b1};
    tbl[3]  = '{8,  17'h00004, 1'b0, 1'b1};
    tbl[4]  = '{15, 17'h07004, 1'b0, 1'b1};
    tbl[5]  = '{16, 17'h00000, 1'b0, 1'b1};
    tbl[6]  = '{18, 17'h00040, 1'b0, 1'b1};
    tbl[7]  = '{19, 17'h00048, 1'b0, 1'b1};
    tbl[8]  = '{26, 17'h07048, 1'b0, 1'b1};
    tbl[9]  = '{27, 17'h00040, 1'b0, 1'b1};
    tbl[10] = '{37, 17'h00000, 1'b0, 1'b1};
    tbl[11] = '{38, 17'h000A0, 1'b0, 1'b1};
    tbl[12] = '{45, 17'h070A0, 1'b0, 1'b1};
    tbl[13] = '{56, 17'h00000, 1'b0, 1'b1};
    tbl[14] = '{57, 17'h10001, 1'b0, 1'b1};
    tbl[15] = '{64, 17'h10701, 1'b0, 1'b1};
    tbl[16] = '{65, 17'h00000, 1'b1, 1'b0};
    tbl[17] = '{66, 17'h00000, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", 32'(inst_a), 32'h0);
    chk("reset_mem_in", mem_a, 32'h0);
    chk("reset_in_ready", 32'(ready_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    chk("reset_done", 32'(done_a), 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Default run, followed by a back-to-back start in the cycle after done.
    run(1'b0, 140, 68, -1);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("tbl_inst_c%0d", tbl[i].cyc), 32'(tr_inst[tbl[i].cyc + 2]), 32'(tbl[i].inst));
      chk($sformatf("tbl_done_c%0d", tbl[i].cyc), 32'(tr_done[tbl[i].cyc + 2]), 32'(tbl[i].done));
      chk($sformatf("tbl_busy_c%0d", tbl[i].cyc), 32'(tr_busy[tbl[i].cyc + 2]), 32'(tbl[i].busy));
    end
    chk("mem_in_q3", tr_mem[5], 32'h76543210);
    chk("mem_in_k3", tr_mem[13], kvec(3));
    chk("mem_in_held", tr_mem[40], kvec(7));
    chk("ready_idle", 32'(tr_rdy[0]), 32'h0);
    chk("ready_qwr", 32'(tr_rdy[1]), 32'h1);
    chk("ready_kwr", 32'(tr_rdy[9]), 32'h1);
    chk("ready_gap", 32'(tr_rdy[17]), 32'h0);
    for (int o = 0; o < 140; o++) begin
      if (o < 70)
        chk($sformatf("run1_o%0d", o), 32'({tr_busy[o], tr_done[o], tr_inst[o]}), 32'(model(o - 2, 8, 8)));
      else
        chk($sformatf("b2b_o%0d", o), 32'({tr_busy[o], tr_done[o], tr_inst[o]}), 32'(model(o - 70, 8, 8)));
    end
    for (int o = 0; o < 40; o++)
      chk($sformatf("small_o%0d", o), 32'(trb[o]), 32'(model(o - 2, 1, 1)));
    chk("small_mem_in", mem_b, kvec(0));

    // A start pulse at cycle 30 must be ignored.
    run(1'b0, 75, 32, -1);
    ndone = 0;
    for (int o = 0; o < 75; o++) begin
      if (tr_done[o]) ndone++;
      chk($sformatf("busystart_o%0d", o), 32'({tr_busy[o], tr_done[o], tr_inst[o]}), 32'(model(o - 2, 8, 8)));
    end
    chk("busystart_done_count", 32'(ndone), 32'd1);

    // Backpressure: in_valid low on alternate QWR cycles, eight stalls.
    run(1'b1, 80, -1, -1);
    ndone = 0;
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("bp_wr_row%0d", r), 32'(tr_inst[3 + 2 * r]), 32'(17'h00010 | (17'(r) << 12)));
      chk($sformatf("bp_mem_row%0d", r), tr_mem[3 + 2 * r], qvec(r));
      chk($sformatf("bp_stall_row%0d", r), 32'(tr_inst[2 + 2 * r]), (r == 0) ? 32'h0 : 32'(17'(r - 1) << 12));
    end
    for (int o = 18; o < 80; o++) begin
      if (tr_done[o]) ndone++;
      chk($sformatf("bp_o%0d", o), 32'({tr_busy[o], tr_done[o], tr_inst[o]}), 32'(model(o - 10, 8, 8)));
    end
    chk("bp_done_count", 32'(ndone), 32'd1);
    chk("bp_done_at_75", 32'(tr_done[75]), 32'h1);

    // Reset during EXEC aborts; the next start runs a full sequence.
    run(1'b0, 50, -1, 44);
    chk("rst_exec_before", 32'(tr_inst[44]), 32'h040A0);
    chk("rst_inst_after", 32'(tr_inst[45]), 32'h0);
    chk("rst_busy_after", 32'(tr_busy[45]), 32'h0);
    chk("rst_ready_after", 32'(tr_rdy[45]), 32'h0);
    chk("rst_idle_tail", 32'(tr_inst[49]), 32'h0);
    run(1'b0, 70, -1, -1);
    for (int o = 0; o < 70; o++)
      chk($sformatf("rerun_o%0d", o), 32'({tr_busy[o], tr_done[o], tr_inst[o]}), 32'(model(o - 2, 8, 8)));
    chk("rerun_mem_q3", tr_mem[5], 32'h76543210);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
